// File: rtl/clk_sup_pkg.sv
// Shared types for the clock lock supervisor.
// Loss counting is built only with LOCK_LOSS_COUNT_EN.
package clk_sup_pkg;

  typedef enum logic [1:0] {
    ST_RST,
    ST_WAIT_LOCK,
    ST_LOCKED,
    ST_FAULT
  } ch_state_e;

  localparam int LOSS_W = 8;
  localparam logic [LOSS_W-1:0] LOSS_MAX = '1;

endpackage

// File: rtl/clock_lock_supervisor_if.sv
// Bundle between the supervisor and its generators.
// loss_count carries data only with LOCK_LOSS_COUNT_EN.
interface clock_lock_supervisor_if #(
  parameter int NUM_CH = 2
);
  import clk_sup_pkg::*;

  logic [NUM_CH-1:0]        locked_in;
  logic [NUM_CH-1:0]        ch_enable;
  logic                     clear_fault;
  logic [NUM_CH-1:0]        dcm_reset;
  logic [NUM_CH-1:0]        clk_ok;
  logic [NUM_CH-1:0]        fault;
  logic                     all_ok;
  logic [LOSS_W*NUM_CH-1:0] loss_count;

  modport master (
    output locked_in,
    output ch_enable,
    output clear_fault,
    input  dcm_reset,
    input  clk_ok,
    input  fault,
    input  all_ok,
    input  loss_count
  );

  modport slave (
    input  locked_in,
    input  ch_enable,
    input  clear_fault,
    output dcm_reset,
    output clk_ok,
    output fault,
    output all_ok,
    output loss_count
  );

endinterface

// File: rtl/clock_lock_channel.sv
// One generator: LOCKED sync, lock FSM, retries.
// LOCK_LOSS_COUNT_EN adds a saturating loss counter.
module clock_lock_channel
  import clk_sup_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int RESET_CYCLES   = 16,
  parameter int STABLE_CYCLES  = 16,
  parameter int MAX_RETRIES    = 7
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_locked,
  input  logic              i_enable,
  input  logic              i_clear,
  output logic              o_dcm_reset,
  output logic              o_clk_ok,
  output logic              o_fault,
  output logic [LOSS_W-1:0] o_loss_count
);

  localparam int TMAX =
    (TIMEOUT_CYCLES > RESET_CYCLES) ?
    TIMEOUT_CYCLES : RESET_CYCLES;
  localparam int TW = $clog2(TMAX) + 1;
  localparam int SW = $clog2(STABLE_CYCLES) + 1;
  localparam int RW = $clog2(MAX_RETRIES) + 1;

  localparam logic [TW-1:0] L_RST_END =
    TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] L_TO_END =
    TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] L_STB_END =
    SW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] L_RTY_MAX =
    RW'(MAX_RETRIES);

  logic [1:0]    r_sync;
  ch_state_e     r_state;
  logic [TW-1:0] r_timer;
  logic [SW-1:0] r_stable;
  logic [RW-1:0] r_retry;

  ch_state_e     w_state;
  logic [TW-1:0] w_timer;
  logic [SW-1:0] w_stable;
  logic [RW-1:0] w_retry;
  logic          w_lock;

  assign w_lock = r_sync[1];

  // Two-flop synchroniser for the async LOCKED pin
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[0], i_locked};
  end

  // State and counter registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_RST;
      r_timer  <= '0;
      r_stable <= '0;
      r_retry  <= '0;
    end else begin
      r_state  <= w_state;
      r_timer  <= w_timer;
      r_stable <= w_stable;
      r_retry  <= w_retry;
    end
  end

  // Next state; lock qualification beats timeout
  always_comb begin
    w_state  = r_state;
    w_timer  = r_timer;
    w_stable = r_stable;
    w_retry  = r_retry;
    if (!i_enable) begin
      w_state  = ST_RST;
      w_timer  = '0;
      w_stable = '0;
      w_retry  = '0;
    end else begin
      unique case (r_state)
        ST_RST: begin
          if (r_timer == L_RST_END) begin
            w_state  = ST_WAIT_LOCK;
            w_timer  = '0;
            w_stable = '0;
          end else begin
            w_timer = r_timer + TW'(1);
          end
        end
        ST_WAIT_LOCK: begin
          w_timer  = r_timer + TW'(1);
          w_stable = w_lock ?
            r_stable + SW'(1) : '0;
          if (w_lock &&
              r_stable == L_STB_END) begin
            w_state  = ST_LOCKED;
            w_timer  = '0;
            w_stable = '0;
            w_retry  = '0;
          end else if (r_timer == L_TO_END) begin
            w_timer  = '0;
            w_stable = '0;
            if (r_retry == L_RTY_MAX) begin
              w_state = ST_FAULT;
            end else begin
              w_state = ST_RST;
              w_retry = r_retry + RW'(1);
            end
          end
        end
        ST_LOCKED: begin
          if (!w_lock) begin
            w_state  = ST_RST;
            w_timer  = '0;
            w_stable = '0;
          end
        end
        ST_FAULT: begin
          if (i_clear) begin
            w_state  = ST_RST;
            w_timer  = '0;
            w_stable = '0;
            w_retry  = '0;
          end
        end
        default: begin
          w_state  = ST_RST;
          w_timer  = '0;
          w_stable = '0;
          w_retry  = '0;
        end
      endcase
    end
  end

  assign o_dcm_reset = (r_state == ST_RST) ||
                       (r_state == ST_FAULT);
  assign o_clk_ok    = (r_state == ST_LOCKED);
  assign o_fault     = (r_state == ST_FAULT);

`ifdef LOCK_LOSS_COUNT_EN
  logic [LOSS_W-1:0] r_loss;
  logic              w_loss_evt;

  assign w_loss_evt = i_enable &&
                      (r_state == ST_LOCKED) &&
                      !w_lock;

  // Saturating lock-loss counter, reset only by rst_n
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_loss <= '0;
    else if (w_loss_evt && r_loss != LOSS_MAX)
      r_loss <= r_loss + LOSS_W'(1);
  end

  assign o_loss_count = r_loss;
`else
  assign o_loss_count = '0;
`endif

endmodule

// File: rtl/clock_lock_supervisor.sv
// Supervises NUM_CH clock generators; all_ok reduce.
// Optional loss counters: LOCK_LOSS_COUNT_EN.
module clock_lock_supervisor
  import clk_sup_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int RESET_CYCLES   = 16,
  parameter int STABLE_CYCLES  = 16,
  parameter int MAX_RETRIES    = 7
) (
  input  logic input_clk,
  input  logic reset_n,
  clock_lock_supervisor_if.slave bus
);

  logic [NUM_CH-1:0]        w_dcm_reset;
  logic [NUM_CH-1:0]        w_clk_ok;
  logic [NUM_CH-1:0]        w_fault;
  logic [LOSS_W*NUM_CH-1:0] w_loss;
  logic                     r_all_ok;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clock_lock_channel #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .RESET_CYCLES   (RESET_CYCLES),
      .STABLE_CYCLES  (STABLE_CYCLES),
      .MAX_RETRIES    (MAX_RETRIES)
    ) u_ch (
      .i_clk        (input_clk),
      .i_rst_n      (reset_n),
      .i_locked     (bus.locked_in[g]),
      .i_enable     (bus.ch_enable[g]),
      .i_clear      (bus.clear_fault),
      .o_dcm_reset  (w_dcm_reset[g]),
      .o_clk_ok     (w_clk_ok[g]),
      .o_fault      (w_fault[g]),
      .o_loss_count (w_loss[g*LOSS_W +: LOSS_W])
    );
  end

  // Aggregate good: all enabled ok, at least one enabled
  always_ff @(posedge input_clk or negedge reset_n) begin
    if (!reset_n)
      r_all_ok <= 1'b0;
    else
      r_all_ok <= (|bus.ch_enable) &&
                  (&(w_clk_ok | ~bus.ch_enable));
  end

  assign bus.dcm_reset  = w_dcm_reset;
  assign bus.clk_ok     = w_clk_ok;
  assign bus.fault      = w_fault;
  assign bus.loss_count = w_loss;
  assign bus.all_ok     = r_all_ok;

endmodule

// File: tb/tb_clock_lock_supervisor.sv
// Bench for clock_lock_supervisor: directed + random.
// Expected loss counts follow LOCK_LOSS_COUNT_EN.
module tb_clock_lock_supervisor;
  import clk_sup_pkg::*;

  localparam int NC = 2;
  localparam int TC = 200;
  localparam int RC = 10;
  localparam int SC = 16;
  localparam int MR = 2;

  localparam int M_RST   = 0;
  localparam int M_WAIT  = 1;
  localparam int M_LOCK  = 2;
  localparam int M_FAULT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clock_lock_supervisor_if #(.NUM_CH(NC)) bus();

  clock_lock_supervisor #(
    .NUM_CH         (NC),
    .TIMEOUT_CYCLES (TC),
    .RESET_CYCLES   (RC),
    .STABLE_CYCLES  (SC),
    .MAX_RETRIES    (MR)
  ) dut (
    .input_clk (clk),
    .reset_n   (rst_n),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int tickn    = 0;

  int m_mode  [NC];
  int m_since [NC];
  int m_run   [NC];
  int m_tries [NC];
  int m_loss  [NC];
  bit m_d1    [NC];
  bit m_d2    [NC];
  bit m_all;

`ifdef LOCK_LOSS_COUNT_EN
  localparam int LOSS_ON = 1;
`else
  localparam int LOSS_ON = 0;
`endif

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h tick %0d",
               nm, act, exp, tickn);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_mode[c]  = M_RST;
      m_since[c] = 0;
      m_run[c]   = 0;
      m_tries[c] = 0;
      m_loss[c]  = 0;
      m_d1[c]    = 1'b0;
      m_d2[c]    = 1'b0;
    end
    m_all = 1'b0;
  endtask

  // One clock edge of the reference behaviour, using
  // the inputs present just before that edge.
  task automatic model_step();
    bit any_en, good, s;
    any_en = |bus.ch_enable;
    good   = 1'b1;
    for (int c = 0; c < NC; c++)
      if (bus.ch_enable[c] && m_mode[c] != M_LOCK)
        good = 1'b0;
    for (int c = 0; c < NC; c++) begin
      s = m_d2[c];
      m_d2[c] = m_d1[c];
      m_d1[c] = bus.locked_in[c];
      if (!bus.ch_enable[c]) begin
        m_mode[c]  = M_RST;
        m_since[c] = 0;
        m_run[c]   = 0;
        m_tries[c] = 0;
      end else if (m_mode[c] == M_RST) begin
        m_since[c]++;
        if (m_since[c] == RC) begin
          m_mode[c]  = M_WAIT;
          m_since[c] = 0;
          m_run[c]   = 0;
        end
      end else if (m_mode[c] == M_WAIT) begin
        m_since[c]++;
        m_run[c] = s ? m_run[c] + 1 : 0;
        if (m_run[c] == SC) begin
          m_mode[c]  = M_LOCK;
          m_tries[c] = 0;
        end else if (m_since[c] == TC) begin
          m_since[c] = 0;
          if (m_tries[c] == MR) begin
            m_mode[c] = M_FAULT;
          end else begin
            m_tries[c]++;
            m_mode[c] = M_RST;
          end
        end
      end else if (m_mode[c] == M_LOCK) begin
        if (!s) begin
          m_mode[c]  = M_RST;
          m_since[c] = 0;
          if (m_loss[c] < 255) m_loss[c]++;
        end
      end else begin
        if (bus.clear_fault) begin
          m_mode[c]  = M_RST;
          m_since[c] = 0;
          m_tries[c] = 0;
        end
      end
    end
    m_all = any_en && good;
  endtask

  task automatic compare();
    logic [NC-1:0] e_dcm, e_ok, e_flt;
    logic [LOSS_W*NC-1:0] e_loss;
    for (int c = 0; c < NC; c++) begin
      e_dcm[c] = (m_mode[c] == M_RST) ||
                 (m_mode[c] == M_FAULT);
      e_ok[c]  = (m_mode[c] == M_LOCK);
      e_flt[c] = (m_mode[c] == M_FAULT);
      e_loss[c*LOSS_W +: LOSS_W] =
        LOSS_ON ? LOSS_W'(m_loss[c]) : '0;
    end
    chk("dcm_reset", bus.dcm_reset, e_dcm);
    chk("clk_ok", bus.clk_ok, e_ok);
    chk("fault", bus.fault, e_flt);
    chk("all_ok", bus.all_ok, m_all);
    chk("loss_count", bus.loss_count, e_loss);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    tickn++;
    compare();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    int dh, k, hi, rises;
    logic pd;

    bus.locked_in   = '0;
    bus.ch_enable   = '1;
    bus.clear_fault = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_dcm", bus.dcm_reset, 2'b11);
    chk("rst_ok", bus.clk_ok, 2'b00);
    chk("rst_fault", bus.fault, 2'b00);
    chk("rst_all", bus.all_ok, 1'b0);
    chk("rst_loss", bus.loss_count, 16'h0);
    compare();
    rst_n = 1'b1;
    tickn = 0;

    // no lock at all: three attempts then fault
    dh = bus.dcm_reset[0] ? 1 : 0;
    k = 0;
    while (!bus.fault[0] && k < 2000) begin
      tick();
      k++;
      if (!bus.fault[0] && bus.dcm_reset[0]) dh++;
    end
    chk("fault0_tick", tickn, 630);
    chk("fault0_rst_cycles", dh, 30);
    repeat (5) tick();
    chk("fault0_hold",
        {bus.fault[0], bus.dcm_reset[0]}, 2'b11);

    // clear restarts with a full reset phase
    bus.clear_fault = 1'b1;
    tick();
    bus.clear_fault = 1'b0;
    chk("clr_fault_gone", bus.fault, 2'b00);
    k = 0;
    while (bus.dcm_reset[0] && k < 50) begin
      tick();
      k++;
    end
    chk("clr_rst_len", k, 10);

    // lock 50 cycles into the wait
    repeat (50) tick();
    bus.locked_in = 2'b11;
    k = 0;
    while (!bus.clk_ok[0] && k < 100) begin
      tick();
      k++;
    end
    chk("lock_latency", k, 18);
    tick();
    chk("all_ok_up", bus.all_ok, 1'b1);

    // clear while locked does nothing
    bus.clear_fault = 1'b1;
    tick();
    bus.clear_fault = 1'b0;
    tick();
    chk("clr_in_locked",
        {bus.clk_ok, bus.fault}, 4'b1100);

    // single-cycle glitch on ch0
    bus.locked_in[0] = 1'b0;
    tick();
    bus.locked_in[0] = 1'b1;
    k = 1;
    while (bus.clk_ok[0] && k < 20) begin
      tick();
      k++;
    end
    chk("loss_latency", k, 3);
    chk("loss_all_lag", bus.all_ok, 1'b1);
    dh = 1;
    tick();
    chk("loss_all_drop", bus.all_ok, 1'b0);
    k = 0;
    while (bus.dcm_reset[0] && k < 50) begin
      dh++;
      tick();
      k++;
    end
    chk("loss_rst_len", dh, 10);
    chk("loss_cnt0", bus.loss_count[7:0],
        LOSS_ON ? 8'd1 : 8'd0);

    // ch1 toggles 15 high / 1 low: never qualifies
    hi = 0;
    rises = 0;
    pd = bus.dcm_reset[1];
    for (int i = 0; i < 700; i++) begin
      bus.locked_in[1] = (i % 16) != 15;
      tick();
      if (i >= 20 && bus.clk_ok[1]) hi++;
      if (i >= 20 && bus.dcm_reset[1] && !pd)
        rises++;
      pd = bus.dcm_reset[1];
    end
    chk("toggle_no_lock", hi, 0);
    chk("toggle_retries", rises, 3);
    chk("toggle_fault1", bus.fault[1], 1'b1);
    chk("toggle_ch0_kept", bus.clk_ok[0], 1'b1);

    // disable ch1 while it waits for lock
    bus.locked_in[1] = 1'b0;
    bus.clear_fault  = 1'b1;
    tick();
    bus.clear_fault  = 1'b0;
    repeat (20) tick();
    chk("dis_pre_dcm1", bus.dcm_reset[1], 1'b0);
    bus.ch_enable = 2'b01;
    tick();
    chk("dis_dcm1", bus.dcm_reset[1], 1'b1);
    tick();
    chk("dis_all_ch0", bus.all_ok, 1'b1);
    bus.ch_enable = 2'b00;
    tick();
    tick();
    chk("none_all", bus.all_ok, 1'b0);
    chk("none_dcm", bus.dcm_reset, 2'b11);

    // random traffic against the model
    bus.ch_enable = 2'b11;
    for (int i = 0; i < 20000; i++) begin
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(63) == 0)
          bus.locked_in[c] = ~bus.locked_in[c];
        if ($urandom_range(799) == 0)
          bus.ch_enable[c] = ~bus.ch_enable[c];
      end
      bus.clear_fault = ($urandom_range(149) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
